gray_conv_arbiter: RTL and testbench

//  Shares one RGB-to-gray converter between two pixel requesters (req0: live camera stream,
//  req1: frame-buffer readback for pupil re-search). Grants in bursts, round-robin, and

---
 rtl/gray_conv_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_gray_conv_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Shares one RGB-to-gray converter between two pixel requesters:
//   req0 = live camera stream, req1 = frame-buffer readback for pupil re-search.
// Requesters are granted in bursts, round-robin. Every pixel sent to the
// converter carries a source tag, and each gray result is routed back to the
// requester that issued the pixel.
//
// Parameters
//   MAX_BURST  max pixels accepted per grant before a forced switch (>=1)
//   CONV_LAT   cycles from oDVAL to the matching iGVAL at the converter (>=1)
//
// Ports
//   iCLK, iRST              clock; synchronous active-high reset
//   iRGB0/iDVAL0/iLAST0     req0 pixel {R[29:20],G[19:10],B[9:0]}, valid, last
//   oRDY0                   req0 pixel accepted when iDVAL0 & oRDY0
//   iRGB1/iDVAL1/iLAST1     req1, same meaning
//   oRDY1                   req1 ready
//   oRed/oGreen/oBlue/oDVAL converter input pixel and valid
//   iGRAY/iGVAL             converter result and valid
//   oGRAY0/oGVAL0           result returned to req0
//   oGRAY1/oGVAL1           result returned to req1
//   oGNT                    one-hot current grant, 00 when idle or switching
//   oERR                    sticky: a result arrived with no pixel in flight
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int CONV_LAT  = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [29:0] iRGB0,
  input  logic        iDVAL0,
  input  logic        iLAST0,
  output logic        oRDY0,
  input  logic [29:0] iRGB1,
  input  logic        iDVAL1,
  input  logic        iLAST1,
  output logic        oRDY1,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oDVAL,
  input  logic [9:0]  iGRAY,
  input  logic        iGVAL,
  output logic [9:0]  oGRAY0,
  output logic        oGVAL0,
  output logic [9:0]  oGRAY1,
  output logic        oGVAL1,
  output logic [1:0]  oGNT,
  output logic        oERR
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_SWITCH
  } state_e;

  // ---------------------------------------------------------------------------
  // Arbiter FSM state
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic          ptr_q;   // round-robin pointer: requester preferred next
  logic          src_q;   // requester currently being served
  logic [CW-1:0] cnt_q;   // pixels accepted in the current burst
  logic [1:0]    gnt_q;   // registered one-hot grant, also drives oRDYn

  // Transfer qualification. Ready comes only from registered grant, so there
  // is no combinational path from iDVAL to oRDY.
  logic        xfer;
  logic        xlast;
  logic        burst_end;
  logic        any_req;
  logic        pick;

  assign xfer      = src_q ? (gnt_q[1] & iDVAL1) : (gnt_q[0] & iDVAL0);
  assign xlast     = src_q ? iLAST1 : iLAST0;
  // iLAST on the final allowed pixel still yields a single switch.
  assign burst_end = xfer & (xlast | (cnt_q == CW'(MAX_BURST - 1)));
  assign any_req   = iDVAL0 | iDVAL1;
  // Pointer's requester wins if it is asking, otherwise the other one
  // (which may re-grant the requester that just finished).
  assign pick      = (ptr_q ? iDVAL1 : iDVAL0) ? ptr_q : ~ptr_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE, ST_SWITCH: begin
          cnt_q <= '0;
          if (any_req) begin
            state_q <= ST_SERVE;
            src_q   <= pick;
            gnt_q   <= pick ? 2'b10 : 2'b01;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
          end
        end
        ST_SERVE: begin
          if (burst_end) begin
            state_q <= ST_SWITCH;
            gnt_q   <= 2'b00;
            ptr_q   <= ~src_q;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: converter input stage, tag pipe, result return
  // ---------------------------------------------------------------------------
  logic [29:0]         rgb_q,   rgb_d;
  logic                dval_q,  dval_d;
  logic                dsrc_q,  dsrc_d;
  logic [CONV_LAT-1:0] tag_v_q, tag_v_d;
  logic [CONV_LAT-1:0] tag_s_q, tag_s_d;
  logic [9:0]          gray0_q, gray0_d;
  logic [9:0]          gray1_q, gray1_d;
  logic                gval0_q, gval0_d;
  logic                gval1_q, gval1_d;
  logic                err_q,   err_d;

  logic head_v;
  logic head_s;

  assign head_v = tag_v_q[CONV_LAT-1];
  assign head_s = tag_s_q[CONV_LAT-1];

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rgb_d   = rgb_q;
    dval_d  = xfer;
    dsrc_d  = src_q;
    tag_v_d = tag_v_q;
    tag_s_d = tag_s_q;
    gray0_d = gray0_q;
    gray1_d = gray1_q;
    gval0_d = 1'b0;
    gval1_d = 1'b0;
    err_d   = err_q;

    if (xfer) begin
      rgb_d = src_q ? iRGB1 : iRGB0;
    end

    // The tag pipe is fed from the converter-input stage, so its head lines
    // up with the cycle in which the converter presents the matching iGVAL.
    tag_v_d[0] = dval_q;
    tag_s_d[0] = dsrc_q;
    for (int i = 1; i < CONV_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_s_d[i] = tag_s_q[i-1];
    end

    if (iGVAL && head_v) begin
      if (head_s) begin
        gval1_d = 1'b1;
        gray1_d = iGRAY;
      end else begin
        gval0_d = 1'b1;
        gray0_d = iGRAY;
      end
    end

    // A result with nothing in flight is dropped and flagged until reset.
    if (iGVAL && !head_v) begin
      err_d = 1'b1;
    end
  end

  // NOTE: the tag pipe is a small memory that is reset explicitly; a stale
  // valid bit after reset would misroute a result instead of flagging oERR.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rgb_q   <= '0;
      dval_q  <= 1'b0;
      dsrc_q  <= 1'b0;
      tag_v_q <= '0;
      tag_s_q <= '0;
      gray0_q <= '0;
      gray1_q <= '0;
      gval0_q <= 1'b0;
      gval1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      dval_q  <= dval_d;
      dsrc_q  <= dsrc_d;
      tag_v_q <= tag_v_d;
      tag_s_q <= tag_s_d;
      gray0_q <= gray0_d;
      gray1_q <= gray1_d;
      gval0_q <= gval0_d;
      gval1_q <= gval1_d;
      err_q   <= err_d;
    end
  end

  assign oRDY0  = gnt_q[0];
  assign oRDY1  = gnt_q[1];
  assign oGNT   = gnt_q;
  assign oRed   = rgb_q[29:20];
  assign oGreen = rgb_q[19:10];
  assign oBlue  = rgb_q[9:0];
  assign oDVAL  = dval_q;
  assign oGRAY0 = gray0_q;
  assign oGVAL0 = gval0_q;
  assign oGRAY1 = gray1_q;
  assign oGVAL1 = gval1_q;
  assign oERR   = err_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Drives gray_conv_arbiter (MAX_BURST=4, CONV_LAT=2) with directed sequences
// and randomized traffic. A converter model returns gray results CONV_LAT
// cycles after oDVAL. A transaction-level reference predicts grants, the
// converter input, and a scoreboard of results due per source.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;

  localparam int MB = 4;
  localparam int CL = 2;
  localparam logic [29:0] ALL1 = 30'h3FFF_FFFF;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [29:0] iRGB0, iRGB1;
  logic        iDVAL0, iLAST0, iDVAL1, iLAST1;
  logic        oRDY0, oRDY1;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oDVAL;
  logic [9:0]  iGRAY;
  logic        iGVAL;
  logic [9:0]  oGRAY0, oGRAY1;
  logic        oGVAL0, oGVAL1;
  logic [1:0]  oGNT;
  logic        oERR;

  gray_conv_arbiter #(.MAX_BURST(MB), .CONV_LAT(CL)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRGB0(iRGB0), .iDVAL0(iDVAL0), .iLAST0(iLAST0), .oRDY0(oRDY0),
    .iRGB1(iRGB1), .iDVAL1(iDVAL1), .iLAST1(iLAST1), .oRDY1(oRDY1),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL),
    .iGRAY(iGRAY), .iGVAL(iGVAL),
    .oGRAY0(oGRAY0), .oGVAL0(oGVAL0), .oGRAY1(oGRAY1), .oGVAL1(oGVAL1),
    .oGNT(oGNT), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [9:0] gray_of(input logic [29:0] p);
    int s;
    s = int'(p[29:20]) + 2 * int'(p[19:10]) + int'(p[9:0]);
    return 10'(s >> 2);
  endfunction

  // ---------------- converter model ----------------
  logic          inj;
  logic [CL-1:0] cv_v;
  logic [9:0]    cv_g [CL];

  always @(posedge iCLK) begin
    if (iRST) begin
      cv_v <= '0;
      for (int i = 0; i < CL; i++) cv_g[i] <= '0;
    end else begin
      cv_v <= {cv_v[CL-2:0], oDVAL};
      cv_g[0] <= gray_of({oRed, oGreen, oBlue});
      for (int i = 1; i < CL; i++) cv_g[i] <= cv_g[i-1];
    end
  end

  assign iGVAL = cv_v[CL-1] | inj;
  assign iGRAY = cv_g[CL-1];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int S_IDLE = 0, S_SERVE = 1, S_GAP = 2;

  typedef struct {
    int         due;
    int         src;
    logic [9:0] g;
  } res_t;

  res_t        sb[$];
  int          m_mode, m_src, m_ptr, m_cnt;
  logic [1:0]  e_gnt;
  logic        e_dval, e_err;
  logic [29:0] e_rgb;
  logic [9:0]  e_gray0, e_gray1;

  function automatic bit mdl_rdy(input int n);
    return (m_mode == S_SERVE) && (m_src == n);
  endfunction

  // Advance the reference by one clock edge using the currently driven inputs.
  function automatic void model_step();
    bit          vld [2];
    bit          lst [2];
    logic [29:0] pix [2];
    bit          xf;
    vld[0] = iDVAL0; vld[1] = iDVAL1;
    lst[0] = iLAST0; lst[1] = iLAST1;
    pix[0] = iRGB0;  pix[1] = iRGB1;
    if (iRST) begin
      m_mode = S_IDLE; m_ptr = 0; m_cnt = 0; m_src = 0;
      e_dval = 1'b0; e_rgb = '0; e_gray0 = '0; e_gray1 = '0; e_err = 1'b0;
      sb.delete();
    end else begin
      xf = (m_mode == S_SERVE) && vld[m_src];
      e_dval = xf;
      if (xf) begin
        e_rgb = pix[m_src];
        sb.push_back('{cyc + CL + 2, m_src, gray_of(pix[m_src])});
      end
      if (inj) e_err = 1'b1;
      if (m_mode == S_SERVE) begin
        if (xf) begin
          m_cnt++;
          if (lst[m_src] || m_cnt == MB) begin
            m_mode = S_GAP;
            m_ptr  = 1 - m_src;
            m_cnt  = 0;
          end
        end
      end else begin
        m_cnt = 0;
        if (vld[m_ptr]) begin
          m_mode = S_SERVE; m_src = m_ptr;
        end else if (vld[1-m_ptr]) begin
          m_mode = S_SERVE; m_src = 1 - m_ptr;
        end else begin
          m_mode = S_IDLE;
        end
      end
    end
    e_gnt = (m_mode == S_SERVE) ? ((m_src == 1) ? 2'b10 : 2'b01) : 2'b00;
  endfunction

  task automatic compare();
    logic ev0, ev1;
    res_t r;
    ev0 = 1'b0;
    ev1 = 1'b0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      r = sb.pop_front();
      if (r.due == cyc) begin
        if (r.src == 0) begin ev0 = 1'b1; e_gray0 = r.g; end
        else            begin ev1 = 1'b1; e_gray1 = r.g; end
      end
    end
    check("gnt",   oGNT,   e_gnt);
    check("rdy0",  oRDY0,  e_gnt[0]);
    check("rdy1",  oRDY1,  e_gnt[1]);
    check("dval",  oDVAL,  e_dval);
    check("rgb",   {oRed, oGreen, oBlue}, e_rgb);
    check("gval0", oGVAL0, ev0);
    check("gval1", oGVAL1, ev1);
    check("gray0", oGRAY0, e_gray0);
    check("gray1", oGRAY1, e_gray1);
    check("err",   oERR,   e_err);
  endtask

  // One clock: drive inputs, advance the reference, sample at the falling edge.
  task automatic cycle(input logic rst,
                       input logic v0, input logic l0, input logic [29:0] p0,
                       input logic v1, input logic l1, input logic [29:0] p1,
                       input logic inj_i);
    iRST = rst;
    iDVAL0 = v0; iLAST0 = l0; iRGB0 = p0;
    iDVAL1 = v1; iLAST1 = l1; iRGB1 = p1;
    inj = inj_i;
    model_step();
    @(posedge iCLK);
    cyc++;
    @(negedge iCLK);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic run_random(input int n);
    logic rr, rj, v0, v1, l0, l1;
    logic [29:0] p0, p1;
    for (int k = 0; k < n; k++) begin
      rr = ($urandom_range(0, 299) == 0);
      rj = !rr && (sb.size() == 0) && ($urandom_range(0, 199) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      l0 = ($urandom_range(0, 5) == 0);
      l1 = ($urandom_range(0, 5) == 0);
      p0 = 30'($urandom());
      p1 = 30'($urandom());
      cycle(rr, v0, l0, p0, v1, l1, p1, rj);
    end
  endtask

  initial begin
    int i;
    bit acc;
    inj = 1'b0;

    // Reset state.
    do_reset(2);

    // 1: req0 alone, 10 white pixels, iLAST on the 10th.
    i = 0;
    for (int guard = 0; guard < 40 && i < 10; guard++) begin
      acc = mdl_rdy(0);
      cycle(1'b0, 1'b1, (i == 9), ALL1, 1'b0, 1'b0, '0, 1'b0);
      if (acc) i++;
    end
    idle(CL + 4);

    // 2: both requesting from reset, no iLAST -> alternating 4-pixel bursts.
    do_reset(1);
    repeat (24) cycle(1'b0, 1'b1, 1'b0, 30'($urandom()), 1'b1, 1'b0, 30'($urandom()), 1'b0);
    idle(CL + 4);

    // 3: req0 stalls for 5 cycles mid-burst while req1 waits.
    do_reset(1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 30'($urandom()), 1'b0, 1'b0, '0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 30'($urandom()), 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 30'($urandom()), 1'b1, 1'b0, 30'($urandom()), 1'b0);
    idle(CL + 4);

    // 4: result injected with nothing in flight -> sticky oERR until reset.
    inj = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(4);
    do_reset(1);
    idle(2);

    // 5: reset mid-burst with pixels in flight -> results lost, pointer back to 0.
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 30'($urandom()), 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 30'($urandom()), 1'b0, 1'b0, '0, 1'b0);
    idle(CL + 4);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 30'($urandom()), 1'b1, 1'b0, 30'($urandom()), 1'b0);
    idle(CL + 4);

    // 6: iLAST on the MAX_BURST-th pixel -> a single switch cycle.
    do_reset(1);
    i = 0;
    repeat (14) begin
      acc = mdl_rdy(0);
      cycle(1'b0, 1'b1, (i == MB - 1), 30'($urandom()), 1'b1, 1'b0, 30'($urandom()), 1'b0);
      if (acc) i++;
    end
    idle(CL + 4);

    // Randomized traffic with occasional resets and spurious results.
    run_random(3000);
    idle(CL + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
